// File: rtl/sfx_event_scheduler.sv
// Sound-effect scheduler: latches one-shot effect requests and plays them one at a time
// on the shared APU tone channel, granting on frame boundaries by fixed priority (id 0 highest).
module sfx_event_scheduler #(
  parameter int unsigned CNT_W = 6,
  parameter int unsigned DUR_0 = 24,
  parameter int unsigned DUR_1 = 12,
  parameter int unsigned DUR_2 = 16,
  parameter int unsigned DUR_3 = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             frame_end,
  input  logic [3:0]       req,
  output logic             sfx_active,
  output logic [1:0]       sfx_id,
  output logic [CNT_W-1:0] sfx_frame,
  output logic             sfx_start,
  output logic             busy_drop
);

  typedef enum logic [0:0] {StIdle, StPlay} state_e;

  state_e           state_q, state_d;
  logic [3:0]       pending_q, pending_d;
  logic [1:0]       id_q, id_d;
  logic [CNT_W-1:0] frame_q, frame_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic             start_q, start_d;
  logic             drop_q, drop_d;

  logic [3:0] eff;
  logic       any_eff;
  logic [1:0] sel;
  logic       load;

  // Last frame index for an effect id (duration minus one).
  function automatic logic [CNT_W-1:0] dur_last(input logic [1:0] id);
    case (id)
      2'd0:    dur_last = CNT_W'(DUR_0 - 1);
      2'd1:    dur_last = CNT_W'(DUR_1 - 1);
      2'd2:    dur_last = CNT_W'(DUR_2 - 1);
      default: dur_last = CNT_W'(DUR_3 - 1);
    endcase
  endfunction

  // Requests arriving in the grant cycle compete alongside latched ones; lowest index wins.
  always_comb begin
    eff     = pending_q | req;
    any_eff = |eff;
    sel     = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (eff[i]) sel = 2'(i);
    end
  end

  // Next-state: mute overrides everything; otherwise decisions happen only on frame_end.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | req;
    id_d      = id_q;
    frame_d   = frame_q;
    remain_d  = remain_q;
    start_d   = 1'b0;
    drop_d    = 1'b0;
    load      = 1'b0;

    if (!enable) begin
      pending_d = '0;
      state_d   = StIdle;
      frame_d   = '0;
      drop_d    = (|pending_q) | (|req);
    end else if (frame_end) begin
      case (state_q)
        StIdle: load = any_eff;
        StPlay: begin
          if (any_eff && (sel <= id_q)) begin
            // Equal or higher priority preempts or retriggers the current effect.
            load = 1'b1;
          end else if (remain_q == '0) begin
            if (any_eff) begin
              load = 1'b1;
            end else begin
              state_d = StIdle;
              frame_d = '0;
            end
          end else begin
            remain_d = remain_q - CNT_W'(1);
            frame_d  = frame_q + CNT_W'(1);
          end
        end
        default: state_d = StIdle;
      endcase

      if (load) begin
        state_d        = StPlay;
        id_d           = sel;
        frame_d        = '0;
        remain_d       = dur_last(sel);
        start_d        = 1'b1;
        // Granted request is consumed even if it is being re-asserted this cycle.
        pending_d[sel] = 1'b0;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      pending_q <= '0;
      id_q      <= '0;
      frame_q   <= '0;
      remain_q  <= '0;
      start_q   <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      id_q      <= id_d;
      frame_q   <= frame_d;
      remain_q  <= remain_d;
      start_q   <= start_d;
      drop_q    <= drop_d;
    end
  end

  assign sfx_active = (state_q == StPlay);
  assign sfx_id     = id_q;
  assign sfx_frame  = frame_q;
  assign sfx_start  = start_q;
  assign busy_drop  = drop_q;

endmodule

// File: tb/tb_sfx_event_scheduler.sv
// Bench for sfx_event_scheduler: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_sfx_event_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       frame_end = 1'b0;
  logic [3:0] req = 4'b0;
  logic       sfx_active;
  logic [1:0] sfx_id;
  logic [5:0] sfx_frame;
  logic       sfx_start;
  logic       busy_drop;

  int tests = 0;
  int fails = 0;
  bit checking = 1'b0;

  // Behavioural model state.
  int dur[4] = '{24, 12, 16, 4};
  bit m_pend[4];
  bit m_act;
  int m_id;
  int m_frame;
  bit m_start;
  bit m_drop;

  sfx_event_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .frame_end (frame_end),
    .req       (req),
    .sfx_active(sfx_active),
    .sfx_id    (sfx_id),
    .sfx_frame (sfx_frame),
    .sfx_start (sfx_start),
    .busy_drop (busy_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: one effect slot plus a set of waiting requests, advanced once per clock edge.
  initial begin
    m_act = 0; m_id = 0; m_frame = 0; m_start = 0; m_drop = 0;
    for (int i = 0; i < 4; i++) m_pend[i] = 0;
    forever begin
      @(posedge clk);
      if (reset) begin
        for (int i = 0; i < 4; i++) m_pend[i] = 0;
        m_act = 0; m_id = 0; m_frame = 0; m_start = 0; m_drop = 0;
      end else if (!enable) begin
        m_drop = 0;
        for (int i = 0; i < 4; i++) begin
          if (m_pend[i] || req[i]) m_drop = 1;
          m_pend[i] = 0;
        end
        m_act = 0; m_frame = 0; m_start = 0;
      end else begin
        int best;
        bit finished;
        m_start = 0; m_drop = 0;
        best = -1;
        for (int i = 0; i < 4; i++) begin
          m_pend[i] = m_pend[i] | req[i];
          if (m_pend[i] && best < 0) best = i;
        end
        if (frame_end) begin
          finished = m_act && (m_frame == dur[m_id] - 1);
          if (best >= 0 && (!m_act || best <= m_id || finished)) begin
            m_act = 1; m_id = best; m_frame = 0; m_start = 1;
            m_pend[best] = 0;
          end else if (finished) begin
            m_act = 0; m_frame = 0;
          end else if (m_act) begin
            m_frame++;
          end
        end
      end
    end
  end

  // Compare DUT outputs against the model away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        check("active", int'(sfx_active), int'(m_act));
        check("id", int'(sfx_id), m_id);
        check("frame", int'(sfx_frame), m_frame);
        check("start", int'(sfx_start), int'(m_start));
        check("busy_drop", int'(busy_drop), int'(m_drop));
      end
    end
  end

  task automatic cyc(input logic e, input logic f, input logic [3:0] r);
    enable = e; frame_end = f; req = r;
    @(negedge clk);
  endtask

  initial begin
    int got_k[3];
    int got_id[3];
    int nstart;

    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    checking = 1'b1;
    check("rst_active", int'(sfx_active), 0);
    check("rst_id", int'(sfx_id), 0);
    check("rst_frame", int'(sfx_frame), 0);

    // All four requested on a frame_end from idle: priority order, back-to-back.
    cyc(1, 1, 4'b1111);
    check("t4_start", int'(sfx_start), 1);
    check("t4_id0", int'(sfx_id), 0);
    for (int i = 0; i < 3; i++) begin got_k[i] = -1; got_id[i] = -1; end
    nstart = 0;
    for (int k = 1; k <= 58; k++) begin
      cyc(1, 0, 4'b0);
      cyc(1, 1, 4'b0);
      if (k == 23) check("t4_last_frame", int'(sfx_frame), 23);
      if (sfx_start) begin
        if (nstart < 3) begin got_k[nstart] = k; got_id[nstart] = int'(sfx_id); end
        nstart++;
      end
    end
    check("t4_nstart", nstart, 3);
    check("t4_k1", got_k[0], 24);
    check("t4_id1", got_id[0], 1);
    check("t4_k2", got_k[1], 36);
    check("t4_id2", got_id[1], 2);
    check("t4_k3", got_k[2], 52);
    check("t4_id3", got_id[2], 3);
    check("t4_idle", int'(sfx_active), 0);

    // Preempt: id2 at frame 5, then id0 takes over.
    cyc(1, 1, 4'b0100);
    for (int k = 0; k < 5; k++) cyc(1, 1, 4'b0);
    check("t3_frame5", int'(sfx_frame), 5);
    cyc(1, 1, 4'b0001);
    check("t3_id", int'(sfx_id), 0);
    check("t3_frame", int'(sfx_frame), 0);
    check("t3_start", int'(sfx_start), 1);

    // Mute with id2 playing and id3 pending.
    cyc(0, 0, 4'b0);
    cyc(1, 1, 4'b0100);
    cyc(1, 0, 4'b1000);
    cyc(0, 0, 4'b0);
    check("t6_active", int'(sfx_active), 0);
    check("t6_drop", int'(busy_drop), 1);
    cyc(1, 1, 4'b0);
    check("t6_stay_idle", int'(sfx_active), 0);
    check("t6_no_start", int'(sfx_start), 0);
    check("t6_drop_gone", int'(busy_drop), 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 6000; n++) begin
      reset     = ($urandom_range(0, 499) == 0);
      enable    = ($urandom_range(0, 39) != 0);
      frame_end = ($urandom_range(0, 3) == 0);
      req       = 4'b0;
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 24) == 0) req[b] = 1'b1;
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
